// File: rtl/enc_sched_pkg.sv
// Shared constants, read-FSM encoding and output bundle for the turbo encoder block scheduler.
package enc_sched_pkg;

   localparam int K_SMALL  = 1056;
   localparam int K_LARGE  = 6144;
   localparam int TAIL_LEN = 6;
   localparam int CNT_W    = 13;

   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] TAIL_CNT  = CNT_W'(TAIL_LEN);
   localparam logic [CNT_W-1:0] TAIL_HALF = CNT_W'(TAIL_LEN / 2);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_DATA = 3'd2,
      ST_TAIL = 3'd3,
      ST_DONE = 3'd4
   } rd_state_t;

   typedef struct packed {
      logic delay_ren;
      logic enc_clr;
      logic enc_en;
      logic close_switch;
      logic tail_mode;
      logic out_valid;
      logic out_tail;
      logic blk_done;
   } rd_out_t;

   function automatic logic [CNT_W-1:0] blk_len(input logic blocksize);
      return blocksize ? CNT_W'(K_LARGE) : CNT_W'(K_SMALL);
   endfunction

endpackage

// File: rtl/enc_block_scheduler_if.sv
// CBS/interleaver handshake inputs and encoder datapath controls of the block scheduler.
interface enc_block_scheduler_if;

   logic       cbs_ready;
   logic       cbs_blocksize;
   logic       int_ready;
   logic       delay_wen;
   logic       delay_ren;
   logic       enc_clr;
   logic       enc_en;
   logic       enc_mode;
   logic       close_switch;
   logic       tail_mode;
   logic       out_valid;
   logic       out_tail;
   logic       blk_done;
   logic       q_full;
   logic       err_ovf;
   logic [2:0] state;

   modport master (
      output cbs_ready, cbs_blocksize, int_ready,
      input  delay_wen, delay_ren, enc_clr, enc_en, enc_mode, close_switch,
             tail_mode, out_valid, out_tail, blk_done, q_full, err_ovf, state
   );

   modport slave (
      input  cbs_ready, cbs_blocksize, int_ready,
      output delay_wen, delay_ren, enc_clr, enc_en, enc_mode, close_switch,
             tail_mode, out_valid, out_tail, blk_done, q_full, err_ovf, state
   );

endinterface

// File: rtl/enc_desc_fifo.sv
// Two-entry, one-bit descriptor queue; a push into a full queue is taken only when a pop
// happens in the same cycle, in which case the popped slot is reused.
module enc_desc_fifo (
   input  logic clk,
   input  logic rst,
   input  logic push,
   input  logic push_dat,
   input  logic pop,
   output logic head,
   output logic full,
   output logic empty
);

   logic [1:0] mem;
   logic       wr_ptr;
   logic       rd_ptr;
   logic [1:0] cnt;
   logic       do_push;
   logic       do_pop;

   assign do_push = push & (~full | pop);
   assign do_pop  = pop & ~empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem    <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         cnt    <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_dat;
            wr_ptr      <= ~wr_ptr;
         end
         if (do_pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 2'd1;
            2'b01:   cnt <= cnt - 2'd1;
            default: cnt <= cnt;
         endcase
      end
   end

   assign head  = mem[rd_ptr];
   assign full  = cnt[1];
   assign empty = (cnt == 2'd0);

endmodule

// File: rtl/enc_block_scheduler.sv
// Turbo encoder block sequencer: write engine fills the delay line per announced block,
// read FSM runs LOAD/DATA/TAIL/DONE per queued descriptor; all outputs are registered.
module enc_block_scheduler
   import enc_sched_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   enc_block_scheduler_if.slave bus
);

   logic [CNT_W-1:0] wcnt;
   logic             wr_busy;
   logic             accept;
   logic             pop;
   logic             q_head;
   logic             q_full;
   logic             q_empty;
   logic             wen_q;
   logic             ovf_q;
   logic             enc_mode_q;

   rd_state_t        st, st_nxt;
   logic [CNT_W-1:0] rcnt, rcnt_nxt;
   rd_out_t          o_nxt, o_q;

   // A pop frees a slot in the same cycle, so fullness never blocks a push then.
   assign wr_busy = (wcnt != '0);
   assign pop     = (st == ST_DONE);
   assign accept  = bus.cbs_ready & ~wr_busy & (~q_full | pop);

   enc_desc_fifo u_desc_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (accept),
      .push_dat (bus.cbs_blocksize),
      .pop      (pop),
      .head     (q_head),
      .full     (q_full),
      .empty    (q_empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wcnt  <= '0;
         wen_q <= 1'b0;
         ovf_q <= 1'b0;
      end else begin
         if (accept) begin
            wcnt <= blk_len(bus.cbs_blocksize);
         end else if (wr_busy) begin
            wcnt <= wcnt - CNT_ONE;
         end
         wen_q <= accept | (wcnt > CNT_ONE);
         ovf_q <= ovf_q | (bus.cbs_ready & ~accept);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st   <= ST_IDLE;
         rcnt <= '0;
      end else begin
         st   <= st_nxt;
         rcnt <= rcnt_nxt;
      end
   end

   always_comb begin
      st_nxt   = st;
      rcnt_nxt = rcnt;
      case (st)
         ST_IDLE: begin
            if (~q_empty && bus.int_ready) begin
               st_nxt = ST_LOAD;
            end
         end
         ST_LOAD: begin
            st_nxt   = ST_DATA;
            rcnt_nxt = blk_len(enc_mode_q);
         end
         ST_DATA: begin
            if (rcnt == CNT_ONE) begin
               st_nxt   = ST_TAIL;
               rcnt_nxt = TAIL_CNT;
            end else if (rcnt != '0) begin
               rcnt_nxt = rcnt - CNT_ONE;
            end
         end
         ST_TAIL: begin
            if (rcnt == CNT_ONE) begin
               st_nxt   = ST_DONE;
               rcnt_nxt = '0;
            end else if (rcnt != '0) begin
               rcnt_nxt = rcnt - CNT_ONE;
            end
         end
         ST_DONE: begin
            st_nxt = ST_IDLE;
         end
         default: begin
            st_nxt   = ST_IDLE;
            rcnt_nxt = '0;
         end
      endcase
   end

   // Decoded from the next state so the registered outputs line up with the state register.
   always_comb begin
      o_nxt = '0;
      case (st_nxt)
         ST_LOAD: begin
            o_nxt.enc_clr = 1'b1;
         end
         ST_DATA: begin
            o_nxt.delay_ren = 1'b1;
            o_nxt.enc_en    = 1'b1;
            o_nxt.out_valid = 1'b1;
         end
         ST_TAIL: begin
            o_nxt.enc_en       = 1'b1;
            o_nxt.close_switch = 1'b1;
            o_nxt.out_valid    = 1'b1;
            o_nxt.out_tail     = 1'b1;
            o_nxt.tail_mode    = (rcnt_nxt <= TAIL_HALF);
         end
         ST_DONE: begin
            o_nxt.blk_done = 1'b1;
         end
         default: begin
            o_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_q        <= '0;
         enc_mode_q <= 1'b0;
      end else begin
         o_q <= o_nxt;
         if (st == ST_IDLE && st_nxt == ST_LOAD) begin
            enc_mode_q <= q_head;
         end
      end
   end

   assign bus.delay_wen    = wen_q;
   assign bus.delay_ren    = o_q.delay_ren;
   assign bus.enc_clr      = o_q.enc_clr;
   assign bus.enc_en       = o_q.enc_en;
   assign bus.enc_mode     = enc_mode_q;
   assign bus.close_switch = o_q.close_switch;
   assign bus.tail_mode    = o_q.tail_mode;
   assign bus.out_valid    = o_q.out_valid;
   assign bus.out_tail     = o_q.out_tail;
   assign bus.blk_done     = o_q.blk_done;
   assign bus.q_full       = q_full;
   assign bus.err_ovf      = ovf_q;
   assign bus.state        = st;

endmodule

// File: tb/tb_enc_block_scheduler.sv
// Bench for enc_block_scheduler: scenario table, hand-written corner sequences, random run vs event model.
module tb_enc_block_scheduler;
   import enc_sched_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   enc_block_scheduler_if bus ();

   enc_block_scheduler dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [14:0] dut_out;
   assign dut_out = {bus.delay_wen, bus.delay_ren, bus.enc_clr, bus.enc_en, bus.enc_mode,
                     bus.close_switch, bus.tail_mode, bus.out_valid, bus.out_tail,
                     bus.blk_done, bus.q_full, bus.err_ovf, bus.state};

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   typedef struct {
      bit       bs;
      int       ir_wait;
      int       exp_wen;
      int       exp_data;
      int       exp_tail;
      int       exp_valid;
      bit [5:0] exp_tmode;
      int       exp_clr;
      int       exp_load_lat;
      int       exp_done_lat;
   } vec_t;

   vec_t vecs[3];

   // Event model: a block accepted at edge n writes cycles n..n+K-1; a block started (LOAD)
   // at cycle L is DATA for L+1..L+K, TAIL for L+K+1..L+K+6, DONE at L+K+7.
   int          mn;
   int          m_wr_last;
   int          m_load;
   int          m_k;
   bit          m_active;
   bit          m_mode;
   bit          m_ovf;
   bit          mq[$];
   logic [14:0] exp_out;

   task automatic model_reset();
      mn = 0; m_wr_last = -10; m_load = 0; m_k = 0;
      m_active = 0; m_mode = 0; m_ovf = 0;
      mq.delete();
   endtask

   task automatic model_step(input bit cbs, input bit bs, input bit ir);
      bit busy, pop, start, acc;
      bit ren, clr, en, cs, tm, ov, ot, bd, wen;
      bit [2:0] st;
      int off;
      mn++;
      busy  = (m_wr_last >= mn - 1);
      pop   = m_active && (mn - 1 == m_load + m_k + TAIL_LEN + 1);
      start = !m_active && (mq.size() > 0) && ir;
      acc   = cbs && !busy && (mq.size() < 2 || pop);
      if (start) begin
         m_active = 1; m_load = mn; m_mode = mq[0];
         m_k = mq[0] ? K_LARGE : K_SMALL;
      end
      if (pop) begin
         m_active = 0;
         void'(mq.pop_front());
      end
      if (acc) begin
         mq.push_back(bs);
         m_wr_last = mn + (bs ? K_LARGE : K_SMALL) - 1;
      end else if (cbs) begin
         m_ovf = 1;
      end
      wen = (m_wr_last >= mn);
      {ren, clr, en, cs, tm, ov, ot, bd} = '0;
      st = 3'd0;
      if (m_active) begin
         off = mn - m_load;
         if (off == 0) begin
            st = 3'd1; clr = 1;
         end else if (off <= m_k) begin
            st = 3'd2; ren = 1; en = 1; ov = 1;
         end else if (off <= m_k + TAIL_LEN) begin
            st = 3'd3; en = 1; cs = 1; ov = 1; ot = 1;
            tm = (off > m_k + TAIL_LEN / 2);
         end else begin
            st = 3'd4; bd = 1;
         end
      end
      exp_out = {wen, ren, clr, en, m_mode, cs, tm, ov, ot, bd, (mq.size() == 2), m_ovf, st};
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.cbs_ready = 1'b0;
      bus.int_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Called at a negedge with the DUT idle; measures one full block.
   task automatic run_scenario(input vec_t v);
      int wen = 0, data = 0, tail = 0, valid = 0, clr = 0, ctrlbad = 0, idlebad = 0;
      int load_i = -1, rise_i = 0, done_i = -1, waitc = 0;
      bit [5:0] tm = '0;
      bus.int_ready     = (v.ir_wait == 0);
      bus.cbs_ready     = 1'b1;
      bus.cbs_blocksize = v.bs;
      @(posedge clk);
      for (int i = 0; i < 20000; i++) begin
         @(negedge clk);
         bus.cbs_ready = 1'b0;
         if (bus.delay_wen) wen++;
         if (bus.out_valid) valid++;
         if (bus.enc_clr) clr++;
         if (bus.state == 3'd2) begin
            data++;
            if (!(bus.delay_ren && bus.enc_en && !bus.out_tail && bus.enc_mode == v.bs)) ctrlbad++;
         end
         if (bus.state == 3'd3) begin
            tail++;
            tm = {tm[4:0], bus.tail_mode};
            if (!(bus.close_switch && bus.out_tail && bus.enc_en)) ctrlbad++;
         end
         if (bus.state == 3'd1 && load_i < 0) load_i = i;
         if (!bus.int_ready && wen > 0 && !bus.delay_wen) begin
            if (bus.state != 3'd0) idlebad++;
            waitc++;
            if (waitc == v.ir_wait) begin
               bus.int_ready = 1'b1;
               rise_i = i;
            end
         end
         if (bus.blk_done) begin
            done_i = i;
            break;
         end
      end
      chk("blk_done_seen", (done_i >= 0), 1);
      chk("wen_cycles", wen, v.exp_wen);
      chk("data_cycles", data, v.exp_data);
      chk("tail_cycles", tail, v.exp_tail);
      chk("valid_cycles", valid, v.exp_valid);
      chk("tail_mode_seq", tm, v.exp_tmode);
      chk("clr_pulses", clr, v.exp_clr);
      chk("data_tail_ctrl", ctrlbad, 0);
      chk("idle_while_waiting", idlebad, 0);
      chk("load_latency", load_i - rise_i, v.exp_load_lat);
      chk("load_to_done", done_i - load_i, v.exp_done_lat);
      @(negedge clk);
      chk("idle_after_done", bus.state, 0);
      chk("q_empty_after", bus.q_full, 0);
   endtask

   initial begin
      int sent2, done1, load2, done2, data_seen, ndone, mseq;
      bit prev_load;
      bit modes[$];

      vecs[0] = '{1'b0, 0,    K_SMALL, K_SMALL, 6, K_SMALL + 6, 6'b000111, 1, 1, K_SMALL + 7};
      vecs[1] = '{1'b1, 0,    K_LARGE, K_LARGE, 6, K_LARGE + 6, 6'b000111, 1, 1, K_LARGE + 7};
      vecs[2] = '{1'b0, 5000, K_SMALL, K_SMALL, 6, K_SMALL + 6, 6'b000111, 1, 1, K_SMALL + 7};

      rst = 1'b1;
      bus.cbs_ready = 1'b0;
      bus.cbs_blocksize = 1'b0;
      bus.int_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", dut_out, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_after_release", dut_out, 0);

      foreach (vecs[k]) run_scenario(vecs[k]);

      // Back-to-back: second announcement in the first cycle the write engine is free.
      do_reset();
      bus.int_ready = 1'b1;
      bus.cbs_ready = 1'b1;
      bus.cbs_blocksize = 1'b0;
      sent2 = -1; done1 = -1; load2 = -1; done2 = -1;
      @(posedge clk);
      for (int i = 0; i < 6000; i++) begin
         @(negedge clk);
         bus.cbs_ready = 1'b0;
         if (sent2 >= 0 && i == sent2 + 1) chk("b2b_q_full_after_push", bus.q_full, 1);
         if (done1 >= 0 && i == done1 + 1) chk("b2b_q_full_after_done", bus.q_full, 0);
         if (bus.blk_done && done1 < 0) begin
            done1 = i;
            chk("b2b_q_full_at_done", bus.q_full, 1);
         end else if (done1 >= 0 && bus.blk_done) begin
            done2 = i;
            break;
         end
         if (done1 >= 0 && bus.state == 3'd1 && load2 < 0) load2 = i;
         if (sent2 < 0 && i > 0 && !bus.delay_wen) begin
            bus.cbs_ready = 1'b1;
            sent2 = i;
         end
      end
      chk("b2b_push_cycle", sent2, K_SMALL);
      chk("b2b_load_gap", load2 - done1, 2);
      chk("b2b_second_block", done2 - load2, K_SMALL + 7);
      chk("b2b_no_ovf", bus.err_ovf, 0);

      // Overflow: drop mid-write, drop on last write cycle, drop when full, push+pop when full.
      do_reset();
      bus.cbs_ready = 1'b1;
      bus.cbs_blocksize = 1'b0;
      ndone = 0; prev_load = 0;
      @(posedge clk);
      for (int i = 0; i < 20000; i++) begin
         @(negedge clk);
         bus.cbs_ready = 1'b0;
         if (bus.state == 3'd2 && prev_load) modes.push_back(bus.enc_mode);
         prev_load = (bus.state == 3'd1);
         if (i == 10) begin
            chk("ovf_clear_before", bus.err_ovf, 0);
            bus.cbs_ready = 1'b1; bus.cbs_blocksize = 1'b1;
         end
         if (i == 11) begin
            chk("ovf_mid_write", bus.err_ovf, 1);
            chk("ovf_mid_write_q", bus.q_full, 0);
         end
         if (i == K_SMALL - 1) bus.cbs_ready = 1'b1;
         if (i == K_SMALL) begin
            chk("ovf_last_cycle_dropped", bus.delay_wen, 0);
            chk("ovf_last_cycle_q", bus.q_full, 0);
            bus.cbs_ready = 1'b1; bus.cbs_blocksize = 1'b1;
         end
         if (i == K_SMALL + 1) begin
            chk("second_push_wen", bus.delay_wen, 1);
            chk("second_push_full", bus.q_full, 1);
         end
         if (i == K_SMALL + K_LARGE + 1) begin
            chk("large_write_len_end", bus.delay_wen, 0);
            bus.cbs_ready = 1'b1; bus.cbs_blocksize = 1'b0;
         end
         if (i == K_SMALL + K_LARGE + 2) begin
            chk("full_drop_wen", bus.delay_wen, 0);
            chk("full_drop_q", bus.q_full, 1);
            chk("full_drop_idle", bus.state, 0);
            bus.int_ready = 1'b1;
         end
         if (i == K_SMALL + K_LARGE + 3 && ndone == 1) begin
            chk("pushpop_q_full", bus.q_full, 1);
         end
         if (bus.blk_done) begin
            ndone++;
            if (ndone == 1) begin
               bus.cbs_ready = 1'b1; bus.cbs_blocksize = 1'b0;
               @(negedge clk);
               bus.cbs_ready = 1'b0;
               chk("pushpop_accepted_wen", bus.delay_wen, 1);
               chk("pushpop_q_full", bus.q_full, 1);
            end
            if (ndone == 3) break;
         end
      end
      chk("ovf_blocks_done", ndone, 3);
      chk("ovf_mode_count", modes.size(), 3);
      mseq = 0;
      foreach (modes[k]) mseq = mseq * 2 + int'(modes[k]);
      chk("ovf_mode_order", mseq, 2);

      // Reset in DATA cycle 500 while the write is still running.
      do_reset();
      bus.int_ready = 1'b1;
      bus.cbs_ready = 1'b1;
      bus.cbs_blocksize = 1'b0;
      data_seen = 0;
      @(posedge clk);
      for (int i = 0; i < 2000 && data_seen < 500; i++) begin
         @(negedge clk);
         bus.cbs_ready = 1'b0;
         if (bus.state == 3'd2) data_seen++;
      end
      chk("reached_data_500", data_seen, 500);
      chk("write_active_at_reset", bus.delay_wen, 1);
      rst = 1'b1;
      #1;
      chk("async_reset_outputs", dut_out, 0);
      bus.int_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("post_reset_idle", dut_out, 0);
      run_scenario(vecs[0]);

      // Random traffic against the event model.
      do_reset();
      model_reset();
      bus.int_ready = 1'b1;
      for (int c = 0; c < 16000; c++) begin
         bus.cbs_ready     = ($urandom_range(0, 249) == 0);
         bus.cbs_blocksize = $urandom_range(0, 1);
         if ($urandom_range(0, 799) == 0) bus.int_ready = ~bus.int_ready;
         model_step(bus.cbs_ready, bus.cbs_blocksize, bus.int_ready);
         @(posedge clk);
         #1;
         chk("random_cycle_outputs", dut_out, exp_out);
         @(negedge clk);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
